// File: rtl/roc_encoder_param.sv
`default_nettype none
// ============================================================================
// Module      : roc_encoder_param
// Description : Rank-order-coding encoder. Emits pixel indices in order of
//               pixel value over the AER input handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module roc_encoder_param #(
  parameter int IMAGE_SIZE      = 7,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_MAX_VALUE = 15,
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [PIXEL_BITS-1:0]      IMAGE [0:IMAGE_SIZE-1],
  input  logic                       NEW_IMAGE,
  input  logic                       ASCENDING,
  input  logic [PIXEL_BITS-1:0]      THRESHOLD,
  input  logic [IMAGE_SIZE_BITS:0]   MAX_SPIKES,
  input  logic                       AERIN_CTRL_BUSY,
  input  logic                       INFERENCE_RDY,
  output logic [9:0]                 NEXT_INDEX,
  output logic                       FOUND_NEXT_INDEX,
  output logic                       ENCODER_RDY,
  output logic [IMAGE_SIZE_BITS:0]   SPIKE_COUNT,
  output logic                       BUSY
);

  localparam int LVL_W = PIXEL_BITS + 1;
  localparam int CNT_W = IMAGE_SIZE_BITS + 1;
  localparam logic [LVL_W-1:0]           LVL_MAX  = LVL_W'(PIXEL_MAX_VALUE);
  localparam logic [IMAGE_SIZE_BITS-1:0] IDX_LAST = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SCAN    = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [PIXEL_BITS-1:0]      pix_q [0:IMAGE_SIZE-1];
  logic                       asc_q;
  logic [PIXEL_BITS-1:0]      thr_q;
  logic [CNT_W-1:0]           max_q;
  logic [IMAGE_SIZE_BITS-1:0] idx_q, idx_d;
  logic [LVL_W-1:0]           lvl_q, lvl_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [9:0]                 nidx_q, nidx_d;
  logic                       found_q, found_d;
  logic                       load;

  logic [LVL_W-1:0]           pix_cur;
  logic [LVL_W-1:0]           end_lvl;
  logic                       hit;
  logic                       empty;
  logic                       cap_hit;
  logic                       adv_done;
  logic [IMAGE_SIZE_BITS-1:0] idx_adv;
  logic [LVL_W-1:0]           lvl_adv;

  // Compare and advance-position logic shared by SCAN and WAIT_LO
  always_comb begin
    pix_cur = {1'b0, pix_q[idx_q]};
    if (pix_cur > LVL_MAX) begin
      pix_cur = LVL_MAX;
    end
    hit      = (pix_cur == lvl_q);
    end_lvl  = asc_q ? LVL_MAX : {1'b0, thr_q};
    empty    = ({1'b0, thr_q} > LVL_MAX);
    cap_hit  = (max_q != '0) && (cnt_q == max_q);
    adv_done = 1'b0;
    idx_adv  = idx_q + 1'b1;
    lvl_adv  = lvl_q;
    if (idx_q == IDX_LAST) begin
      idx_adv = '0;
      if (lvl_q == end_lvl) begin
        adv_done = 1'b1;
      end else begin
        lvl_adv = asc_q ? (lvl_q + 1'b1) : (lvl_q - 1'b1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    nidx_d  = nidx_q;
    found_d = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (NEW_IMAGE) begin
          load    = 1'b1;
          state_d = S_SCAN;
          idx_d   = '0;
          cnt_d   = '0;
          lvl_d   = ASCENDING ? {1'b0, THRESHOLD} : LVL_MAX;
        end
      end
      S_SCAN: begin
        // Abort wins over a match so no strobe follows INFERENCE_RDY
        if (INFERENCE_RDY || empty) begin
          state_d = S_DONE;
        end else if (hit) begin
          found_d = 1'b1;
          nidx_d  = 10'(idx_q);
          cnt_d   = cnt_q + 1'b1;
          state_d = S_WAIT_HI;
        end else if (adv_done) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_adv;
          lvl_d = lvl_adv;
        end
      end
      S_WAIT_HI: begin
        if (INFERENCE_RDY) begin
          state_d = S_DONE;
        end else if (AERIN_CTRL_BUSY) begin
          state_d = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (INFERENCE_RDY) begin
          state_d = S_DONE;
        end else if (!AERIN_CTRL_BUSY) begin
          if (cap_hit || adv_done) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
            idx_d   = idx_adv;
            lvl_d   = lvl_adv;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lvl_q   <= '0;
      cnt_q   <= '0;
      nidx_q  <= '0;
      found_q <= 1'b0;
      asc_q   <= 1'b0;
      thr_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      nidx_q  <= nidx_d;
      found_q <= found_d;
      if (load) begin
        asc_q <= ASCENDING;
        thr_q <= THRESHOLD;
        max_q <= MAX_SPIKES;
      end
    end
  end

  // Image store carries no reset; it is always written before being scanned
  always_ff @(posedge CLK) begin
    if (load && !RST) begin
      pix_q <= IMAGE;
    end
  end

  assign NEXT_INDEX       = nidx_q;
  assign FOUND_NEXT_INDEX = found_q;
  assign SPIKE_COUNT      = cnt_q;
  assign ENCODER_RDY      = (state_q == S_DONE);
  assign BUSY             = (state_q == S_SCAN) || (state_q == S_WAIT_HI) ||
                            (state_q == S_WAIT_LO);

endmodule
`default_nettype wire

// File: tb/tb_roc_encoder_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_roc_encoder_param
// Description : Scoreboard bench for roc_encoder_param, directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_roc_encoder_param;

  typedef logic [3:0] img_t [0:6];

  logic       CLK = 1'b0;
  logic       RST;
  img_t       IMAGE;
  logic       NEW_IMAGE;
  logic       ASCENDING;
  logic [3:0] THRESHOLD;
  logic [3:0] MAX_SPIKES;
  logic       AERIN_CTRL_BUSY;
  logic       INFERENCE_RDY;
  logic [9:0] NEXT_INDEX;
  logic       FOUND_NEXT_INDEX;
  logic       ENCODER_RDY;
  logic [3:0] SPIKE_COUNT;
  logic       BUSY;

  int checks = 0;
  int errors = 0;
  int exp_q [$];
  logic aer_auto = 1'b1;

  img_t img_a;
  img_t img_b;
  img_t img_z;
  int ord_desc [7] = '{1, 3, 6, 4, 0, 5, 2};
  int ord_asc2 [5] = '{0, 4, 6, 1, 3};

  always #5 CLK = ~CLK;

  roc_encoder_param dut (
    .CLK              (CLK),
    .RST              (RST),
    .IMAGE            (IMAGE),
    .NEW_IMAGE        (NEW_IMAGE),
    .ASCENDING        (ASCENDING),
    .THRESHOLD        (THRESHOLD),
    .MAX_SPIKES       (MAX_SPIKES),
    .AERIN_CTRL_BUSY  (AERIN_CTRL_BUSY),
    .INFERENCE_RDY    (INFERENCE_RDY),
    .NEXT_INDEX       (NEXT_INDEX),
    .FOUND_NEXT_INDEX (FOUND_NEXT_INDEX),
    .ENCODER_RDY      (ENCODER_RDY),
    .SPIKE_COUNT      (SPIKE_COUNT),
    .BUSY             (BUSY)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue
  always @(negedge CLK) begin
    int exp_v;
    if (FOUND_NEXT_INDEX) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got index %0d expected no strobe", NEXT_INDEX);
      end else begin
        exp_v = exp_q.pop_front();
        if (int'(NEXT_INDEX) != exp_v) begin
          errors++;
          $display("FAIL strobe_index: got %0d expected %0d", NEXT_INDEX, exp_v);
        end
      end
    end
  end

  // AER controller model: busy rises one cycle after the strobe, held two cycles
  initial begin
    AERIN_CTRL_BUSY = 1'b0;
    forever begin
      @(negedge CLK);
      if (aer_auto && FOUND_NEXT_INDEX) begin
        @(negedge CLK);
        AERIN_CTRL_BUSY = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        AERIN_CTRL_BUSY = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic start_image(input img_t img, input logic asc, input logic [3:0] thr,
                             input logic [3:0] maxs);
    @(negedge CLK);
    IMAGE      = img;
    ASCENDING  = asc;
    THRESHOLD  = thr;
    MAX_SPIKES = maxs;
    NEW_IMAGE  = 1'b1;
    @(negedge CLK);
    NEW_IMAGE = 1'b0;
    chk("busy_after_start", int'(BUSY), 1);
    chk("rdy_low_after_start", int'(ENCODER_RDY), 0);
    chk("count_cleared", int'(SPIKE_COUNT), 0);
  endtask

  task automatic wait_done(input int exp_cnt, output int cyc);
    cyc = 0;
    while (!ENCODER_RDY && cyc < 3000) begin
      @(negedge CLK);
      cyc++;
    end
    chk("encoder_rdy", int'(ENCODER_RDY), 1);
    chk("busy_low_done", int'(BUSY), 0);
    repeat (8) @(negedge CLK);
    chk("spike_count", int'(SPIKE_COUNT), exp_cnt);
    chk("all_indices_seen", exp_q.size(), 0);
    chk("rdy_held", int'(ENCODER_RDY), 1);
  endtask

  task automatic wait_strobe();
    int n;
    n = 0;
    while (!FOUND_NEXT_INDEX && n < 500) begin
      @(negedge CLK);
      n++;
    end
    chk("strobe_seen", int'(FOUND_NEXT_INDEX), 1);
  endtask

  initial begin
    int cyc;
    img_a = '{4'd3, 4'd15, 4'd0, 4'd15, 4'd7, 4'd1, 4'd9};
    img_b = '{4'd9, 4'd1, 4'd7, 4'd15, 4'd0, 4'd15, 4'd3};
    img_z = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    RST = 1'b1;
    IMAGE = img_z;
    NEW_IMAGE = 1'b0;
    ASCENDING = 1'b0;
    THRESHOLD = 4'd0;
    MAX_SPIKES = 4'd0;
    INFERENCE_RDY = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_next_index", int'(NEXT_INDEX), 0);
    chk("rst_found", int'(FOUND_NEXT_INDEX), 0);
    chk("rst_rdy", int'(ENCODER_RDY), 0);
    chk("rst_count", int'(SPIKE_COUNT), 0);
    chk("rst_busy", int'(BUSY), 0);
    RST = 1'b0;

    // Descending, full image
    foreach (ord_desc[i]) exp_q.push_back(ord_desc[i]);
    start_image(img_a, 1'b0, 4'd0, 4'd0);
    wait_done(7, cyc);

    // Ascending with threshold 2
    foreach (ord_asc2[i]) exp_q.push_back(ord_asc2[i]);
    start_image(img_a, 1'b1, 4'd2, 4'd0);
    wait_done(5, cyc);

    // Spike cap of 2
    exp_q.push_back(1);
    exp_q.push_back(3);
    start_image(img_a, 1'b0, 4'd0, 4'd2);
    wait_done(2, cyc);

    // Abort in WAIT_LO after the first strobe
    exp_q.push_back(1);
    start_image(img_a, 1'b0, 4'd0, 4'd0);
    wait_strobe();
    @(negedge CLK);
    @(negedge CLK);
    INFERENCE_RDY = 1'b1;
    @(negedge CLK);
    INFERENCE_RDY = 1'b0;
    chk("abort_rdy_next_cycle", int'(ENCODER_RDY), 1);
    chk("abort_count", int'(SPIKE_COUNT), 1);
    wait_done(1, cyc);

    // Empty scan: 15 levels x 7 pixels
    start_image(img_z, 1'b0, 4'd1, 4'd0);
    wait_done(0, cyc);
    chk("empty_scan_cycles", cyc, 105);

    // Mid-scan NEW_IMAGE with different image and config is ignored
    foreach (ord_desc[i]) exp_q.push_back(ord_desc[i]);
    start_image(img_a, 1'b0, 4'd0, 4'd0);
    IMAGE      = img_b;
    ASCENDING  = 1'b1;
    THRESHOLD  = 4'd5;
    MAX_SPIKES = 4'd1;
    NEW_IMAGE  = 1'b1;
    @(negedge CLK);
    NEW_IMAGE = 1'b0;
    wait_done(7, cyc);

    // Reset while parked in WAIT_HI, then a fresh image
    aer_auto = 1'b0;
    exp_q.push_back(1);
    start_image(img_a, 1'b0, 4'd0, 4'd0);
    wait_strobe();
    @(negedge CLK);
    chk("parked_busy", int'(BUSY), 1);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_next_index", int'(NEXT_INDEX), 0);
    chk("mid_rst_found", int'(FOUND_NEXT_INDEX), 0);
    chk("mid_rst_rdy", int'(ENCODER_RDY), 0);
    chk("mid_rst_count", int'(SPIKE_COUNT), 0);
    chk("mid_rst_busy", int'(BUSY), 0);
    RST = 1'b0;
    aer_auto = 1'b1;
    foreach (ord_asc2[i]) exp_q.push_back(ord_asc2[i]);
    start_image(img_a, 1'b1, 4'd2, 4'd0);
    wait_done(5, cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
